vote_session_ctrl: RTL and testbench
====================================

// Module: vote_session_ctrl
//
// PURPOSE
//  Sequences one ballot of the 5-voter majority voting datapath. Opens a session on start,
//  latches at most one vote per voter, and closes on all-cast, close request or timeout.
//  Then tallies the yes votes and holds the pass/fail result until it is acknowledged.
//  Sits between the voter input buttons and the result LEDs of the voting board design.
//
// PARAMETERS
//  N_VOTERS     5     number of voters (width of vote vectors)
//  THRESH       3     minimum yes count for pass (majority of N_VOTERS)
//  TIMEOUT_CYC  1000  max cycles a session stays open; must be >= 2
//
// PORTS
//  clk         in   1            system clock, rising edge
//  rst_n       in   1            asynchronous active-low reset
//  start       in   1            open a new session (level sampled per cycle)
//  close       in   1            force the session closed early
//  vote_en     in   N_VOTERS     per-voter vote strobe
//  vote_val    in   N_VOTERS     per-voter ballot, 1=yes, 0=no; qualified by vote_en
//  ack         in   1            result consumed; return to IDLE
//  busy        out  1            session open (state OPEN)
//  cast_mask   out  N_VOTERS     voters who have voted this session
//  yes_cnt     out  clog2(N+1)   tallied yes count
//  pass        out  1            yes_cnt >= THRESH
//  result_vld  out  1            result valid (state RESULT)
//  dup_err     out  1            1-cycle pulse: a voter that already voted strobed again
//
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs, ballots, cast_mask, timer = 0.
//  - FSM: IDLE -> OPEN -> TALLY -> RESULT -> IDLE/OPEN. Registered outputs only.
//  - IDLE: start=1 -> OPEN next cycle; clears cast_mask, ballots, yes_cnt, pass, timer.
//  - OPEN: busy=1; timer increments each cycle from 0.
//    * vote_en[i]=1 & cast_mask[i]=0 -> cast_mask[i]<=1, ballot[i]<=vote_val[i].
//    * vote_en[i]=1 & cast_mask[i]=1 -> ballot unchanged; dup_err=1 next cycle.
//    * Any number of voters may vote in the same cycle; all are accepted.
//    * Exit to TALLY when cast_mask (registered) is all ones, or close=1, or
//      timer==TIMEOUT_CYC-1. Votes strobed in the same cycle as close/timeout
//      are still accepted. Exit is evaluated on registered cast_mask, so the
//      cycle after the last vote is the last OPEN cycle.
//    * start while OPEN is ignored.
//  - TALLY (1 cycle): yes_cnt <= popcount(ballot & cast_mask); voters not
//    cast count as no. pass computed from that count, valid in RESULT.
//  - RESULT: result_vld=1; yes_cnt, pass, cast_mask held stable.
//    * start=1 -> OPEN (start wins over ack in same cycle); else ack=1 -> IDLE.
//    * Leaving RESULT clears result_vld; yes_cnt/pass held until next start.
//  - Latency: last vote to result_vld = 3 cycles (mask reg, OPEN exit, TALLY).
//  - Timer width clog2(TIMEOUT_CYC); never wraps (session closes first).
//  - dup_err is a pulse; inputs in IDLE/TALLY/RESULT produce no dup_err and no effect.
//  - rst_n low mid-session aborts immediately; no partial result is ever shown.
//
// TESTING
//  1. Reset, idle 5 cycles -> busy=0, result_vld=0, yes_cnt=0, pass=0, cast_mask=0.
//  2. start; votes A=1,B=1,C=1,D=0,E=0 on separate cycles -> result_vld=1, yes_cnt=3,
//     pass=1, cast_mask=5'b11111, result_vld 3 cycles after E's vote.
//  3. start; A votes 1 then again with 0 -> dup_err pulse 1 cycle, A stays yes;
//     B..E vote 0 -> yes_cnt=1, pass=0.
//  4. start; A=1,C=1 only, no close -> closes after TIMEOUT_CYC cycles, cast_mask=5'b00101,
//     yes_cnt=2, pass=0; ack -> IDLE, result_vld=0.
//  5. start; all five vote 1 in one cycle -> yes_cnt=5, pass=1; then start+ack same cycle
//     in RESULT -> OPEN, cast_mask cleared.
//  6. start; A,B vote 1; rst_n low 1 cycle -> IDLE, all outputs 0; next session unaffected.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: runs one ballot of the 5-voter majority board.
// A session opens on start, accepts at most one vote per voter, then closes
// when everyone has voted, on an explicit close, or when the timer expires.
// One tally cycle later the yes count and pass/fail are presented until acked.
module vote_session_ctrl #(
    parameter  int N_VOTERS    = 5,
    parameter  int THRESH      = 3,
    parameter  int TIMEOUT_CYC = 1000,
    localparam int CNT_W       = $clog2(N_VOTERS + 1),
    localparam int TMR_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                close,
    input  logic [N_VOTERS-1:0] vote_en,
    input  logic [N_VOTERS-1:0] vote_val,
    input  logic                ack,
    output logic                busy,
    output logic [N_VOTERS-1:0] cast_mask,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic                pass,
    output logic                result_vld,
    output logic                dup_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_TALLY  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t              state_reg;
    logic [N_VOTERS-1:0] ballot_reg;
    logic [TMR_W-1:0]    timer_reg;

    logic [N_VOTERS-1:0] accept;
    logic [N_VOTERS-1:0] dup_hit;
    logic [N_VOTERS-1:0] cast_next;
    logic [N_VOTERS-1:0] ballot_next;
    logic [N_VOTERS-1:0] yes_bits;
    logic [CNT_W-1:0]    tally;
    logic                last_tick;
    logic                close_now;

    // Per-voter accept/duplicate decode against the registered cast mask.
    generate
        for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_voter
            assign accept[gi]      = vote_en[gi] & ~cast_mask[gi];
            assign dup_hit[gi]     = vote_en[gi] &  cast_mask[gi];
            assign cast_next[gi]   = cast_mask[gi] | vote_en[gi];
            assign ballot_next[gi] = accept[gi] ? vote_val[gi] : ballot_reg[gi];
            // A voter who never cast is counted as a no regardless of ballot.
            assign yes_bits[gi]    = ballot_reg[gi] & cast_mask[gi];
        end
    endgenerate

    // Population count of yes ballots among voters who actually cast.
    always_comb begin
        tally = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            tally = tally + CNT_W'(yes_bits[i]);
        end
    end

    // The session lasts TIMEOUT_CYC cycles at most: timer runs 0..TIMEOUT_CYC-1.
    assign last_tick = (timer_reg == TMR_W'(TIMEOUT_CYC - 1));
    // Exit uses the registered mask, so the cycle after the final vote is still open.
    assign close_now = (&cast_mask) | close | last_tick;

    // Session sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            ballot_reg <= '0;
            timer_reg  <= '0;
            busy       <= 1'b0;
            cast_mask  <= '0;
            yes_cnt    <= '0;
            pass       <= 1'b0;
            result_vld <= 1'b0;
            dup_err    <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg  <= S_OPEN;
                        busy       <= 1'b1;
                        cast_mask  <= '0;
                        ballot_reg <= '0;
                        yes_cnt    <= '0;
                        pass       <= 1'b0;
                        timer_reg  <= '0;
                    end
                end
                S_OPEN: begin
                    // Votes arriving alongside close/timeout are still latched.
                    cast_mask  <= cast_next;
                    ballot_reg <= ballot_next;
                    dup_err    <= |dup_hit;
                    if (close_now) begin
                        state_reg <= S_TALLY;
                        busy      <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                S_TALLY: begin
                    yes_cnt    <= tally;
                    pass       <= (tally >= CNT_W'(THRESH));
                    result_vld <= 1'b1;
                    state_reg  <= S_RESULT;
                end
                S_RESULT: begin
                    // A new start takes priority over acknowledging the old result.
                    if (start) begin
                        state_reg  <= S_OPEN;
                        busy       <= 1'b1;
                        result_vld <= 1'b0;
                        cast_mask  <= '0;
                        ballot_reg <= '0;
                        yes_cnt    <= '0;
                        pass       <= 1'b0;
                        timer_reg  <= '0;
                    end else if (ack) begin
                        state_reg  <= S_IDLE;
                        result_vld <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: directed ballots with literal expectations,
// then random traffic, all compared every cycle against a session-level model.
module tb_vote_session_ctrl;

    localparam int N           = 5;
    localparam int THRESH      = 3;
    localparam int TIMEOUT_CYC = 1000;
    localparam int CNT_W       = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            close = 1'b0;
    logic            ack = 1'b0;
    logic [N-1:0]    vote_en = '0;
    logic [N-1:0]    vote_val = '0;
    logic            busy;
    logic [N-1:0]    cast_mask;
    logic [CNT_W-1:0] yes_cnt;
    logic            pass;
    logic            result_vld;
    logic            dup_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vote_session_ctrl #(
        .N_VOTERS(N), .THRESH(THRESH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close),
        .vote_en(vote_en), .vote_val(vote_val), .ack(ack),
        .busy(busy), .cast_mask(cast_mask), .yes_cnt(yes_cnt),
        .pass(pass), .result_vld(result_vld), .dup_err(dup_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Session-level view: whether a ballot is open and for how long, which
    // voters are in, whether a result is pending or on display.
    typedef struct packed {
        logic         open;
        logic         closing;
        logic         shown;
        logic         pass;
        logic         dup;
        int           age;
        int           cnt;
        logic [N-1:0] cast;
        logic [N-1:0] yes;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t s, input logic st, input logic cl,
                                          input logic [N-1:0] en, input logic [N-1:0] val,
                                          input logic ak);
        model_t r = s;
        int voted = 0;
        r.dup = 1'b0;
        if (s.closing) begin
            // Result appears one cycle after the ballot closes.
            r.cnt = 0;
            for (int i = 0; i < N; i++) if (s.cast[i] && s.yes[i]) r.cnt++;
            r.pass    = (r.cnt >= THRESH);
            r.shown   = 1'b1;
            r.closing = 1'b0;
        end else if (s.open) begin
            for (int i = 0; i < N; i++) if (s.cast[i]) voted++;
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    if (s.cast[i]) r.dup = 1'b1;
                    else begin
                        r.cast[i] = 1'b1;
                        r.yes[i]  = val[i];
                    end
                end
            end
            r.age = s.age + 1;
            if (voted == N || cl || r.age == TIMEOUT_CYC) begin
                r.open    = 1'b0;
                r.closing = 1'b1;
            end
        end else if (st) begin
            r       = '0;
            r.open  = 1'b1;
        end else if (s.shown && ak) begin
            r.shown = 1'b0;
        end
        return r;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, start, close, vote_en, vote_val, ack);
    end

    // Compare every output on every cycle, half a period after the edge.
    always @(negedge clk) begin
        check("busy",       int'(busy),       int'(m.open));
        check("cast_mask",  int'(cast_mask),  int'(m.cast & {N{~m.closing | 1'b1}}));
        check("yes_cnt",    int'(yes_cnt),    m.cnt);
        check("pass",       int'(pass),       int'(m.pass));
        check("result_vld", int'(result_vld), int'(m.shown));
        check("dup_err",    int'(dup_err),    int'(m.dup));
    end

    task automatic drive(input logic s, input logic c, input logic [N-1:0] en,
                         input logic [N-1:0] val, input logic a);
        start = s; close = c; vote_en = en; vote_val = val; ack = a;
        @(negedge clk);
        start = 1'b0; close = 1'b0; vote_en = '0; vote_val = '0; ack = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_result();
        int cyc = 0;
        while (!result_vld && cyc < 20) begin
            idle();
            cyc++;
        end
        if (!result_vld) check("result_wait", 0, 1);
    endtask

    initial begin
        int lat;
        int open_cyc;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: quiet after reset
        repeat (5) idle();
        check("t1_busy", int'(busy), 0);
        check("t1_result_vld", int'(result_vld), 0);
        check("t1_yes_cnt", int'(yes_cnt), 0);
        check("t1_pass", int'(pass), 0);
        check("t1_cast_mask", int'(cast_mask), 0);

        // 2: five separate votes, 3 yes
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 5'b00001, 5'b00001, 1'b0);
        drive(1'b0, 1'b0, 5'b00010, 5'b00010, 1'b0);
        drive(1'b0, 1'b0, 5'b00100, 5'b00100, 1'b0);
        drive(1'b0, 1'b0, 5'b01000, 5'b00000, 1'b0);
        drive(1'b0, 1'b0, 5'b10000, 5'b00000, 1'b0);
        lat = 1;
        while (!result_vld && lat < 20) begin
            idle();
            lat++;
        end
        check("t2_latency", lat, 3);
        check("t2_yes_cnt", int'(yes_cnt), 3);
        check("t2_pass", int'(pass), 1);
        check("t2_cast_mask", int'(cast_mask), 5'b11111);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("t2_ack_idle", int'(result_vld), 0);

        // 3: duplicate vote by A is flagged and ignored
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 5'b00001, 5'b00001, 1'b0);
        drive(1'b0, 1'b0, 5'b00001, 5'b00000, 1'b0);
        check("t3_dup_pulse", int'(dup_err), 1);
        idle();
        check("t3_dup_clear", int'(dup_err), 0);
        drive(1'b0, 1'b0, 5'b11110, 5'b00000, 1'b0);
        wait_result();
        check("t3_yes_cnt", int'(yes_cnt), 1);
        check("t3_pass", int'(pass), 0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);

        // 4: partial turnout, session times out
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        open_cyc = busy ? 1 : 0;
        drive(1'b0, 1'b0, 5'b00101, 5'b00101, 1'b0);
        if (busy) open_cyc++;
        while (busy && open_cyc < 1100) begin
            idle();
            if (busy) open_cyc++;
        end
        check("t4_open_cycles", open_cyc, TIMEOUT_CYC);
        wait_result();
        check("t4_cast_mask", int'(cast_mask), 5'b00101);
        check("t4_yes_cnt", int'(yes_cnt), 2);
        check("t4_pass", int'(pass), 0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("t4_ack_rvld", int'(result_vld), 0);
        check("t4_ack_busy", int'(busy), 0);

        // 5: unanimous single-cycle vote, then start+ack together
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 5'b11111, 5'b11111, 1'b0);
        wait_result();
        check("t5_yes_cnt", int'(yes_cnt), 5);
        check("t5_pass", int'(pass), 1);
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        check("t5_restart_busy", int'(busy), 1);
        check("t5_restart_rvld", int'(result_vld), 0);
        check("t5_restart_mask", int'(cast_mask), 0);
        drive(1'b0, 1'b1, '0, '0, 1'b0);
        wait_result();
        check("t5_empty_yes", int'(yes_cnt), 0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);

        // 6: reset mid-session, next session clean
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 5'b00011, 5'b00011, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_mask", int'(cast_mask), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 5'b11100, 5'b11100, 1'b0);
        drive(1'b0, 1'b0, 5'b00011, 5'b00000, 1'b0);
        check("t6_no_dup", int'(dup_err), 0);
        wait_result();
        check("t6_yes_cnt", int'(yes_cnt), 3);
        check("t6_pass", int'(pass), 1);
        check("t6_cast_mask", int'(cast_mask), 5'b11111);
        drive(1'b0, 1'b0, '0, '0, 1'b1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(7) == 0);
            close = ($urandom_range(24) == 0);
            ack   = ($urandom_range(3) == 0);
            for (int i = 0; i < N; i++) vote_en[i] = ($urandom_range(5) == 0);
            vote_val = N'($urandom);
            if ($urandom_range(599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; close = 1'b0; ack = 1'b0; vote_en = '0; vote_val = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
